// File: rtl/frame_buffer_fetch.sv
// ---------------------------------------------------------------------------
// frame_buffer_fetch
//
// Turns one scan-out read request (base address + block count) into a burst
// of single-beat DDR app read commands and gathers the returned beats into
// one wide cache block. The block is handed back with a one-cycle Valid
// pulse.
//
// Ports
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   mem_request          ReadStrobe / ReadAddress / BlockCount from reader
//   read_data            Valid pulse, echoed ReadAddress, gathered Data
//   app_addr/app_cmd/app_en/app_rdy
//                        DDR app command channel (reads only)
//   app_rd_data/app_rd_data_valid
//                        DDR app read-return channel, in command order
//   busy                 high whenever the fetch FSM is not idle
//
// The request/response structs live in frame_buffer_fetch_pkg. Their field
// widths are fixed by the package, so the module parameters must keep
// ADDR_WIDTH == FB_ADDR_W and MAX_BEATS*APP_DATA_WIDTH == FB_DATA_W.
// ---------------------------------------------------------------------------

package frame_buffer_fetch_pkg;
    localparam int FB_ADDR_W  = 28;
    localparam int FB_DATA_W  = 512;   // MAX_BEATS * APP_DATA_WIDTH
    localparam int FB_COUNT_W = 8;

    typedef struct packed {
        logic                  ReadStrobe;
        logic [FB_ADDR_W-1:0]  ReadAddress;
        logic [FB_COUNT_W-1:0] BlockCount;
    } MemoryReadRequest;

    typedef struct packed {
        logic                  Valid;
        logic [FB_ADDR_W-1:0]  ReadAddress;
        logic [FB_DATA_W-1:0]  Data;
    } MemoryReadData;
endpackage

// ---------------------------------------------------------------------------
// fb_beat_slot: one beat-wide storage lane of the gather buffer.
//   clr  wipes the lane when a new request is loaded
//   we   captures d (only the lane addressed by the receive counter)
// ---------------------------------------------------------------------------
module fb_beat_slot #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)  q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= d;
    end
endmodule

module frame_buffer_fetch
    import frame_buffer_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH     = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int DQ_WIDTH       = 16,
    parameter int MAX_BEATS      = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  MemoryReadRequest          mem_request,
    output MemoryReadData             read_data,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    input  logic                      app_rdy,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    input  logic                      app_rd_data_valid,
    output logic                      busy
);
    localparam int STRIDE = APP_DATA_WIDTH / DQ_WIDTH;
    localparam int CW     = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [CW-1:0]           beats;
    logic [CW-1:0]           issued;
    logic [CW-1:0]           received;
    logic                    pend_vld;
    logic [ADDR_WIDTH-1:0]   pend_addr;
    logic [CW-1:0]           pend_beats;

    // Clamp the requested block count to what one cache block can hold.
    function automatic logic [CW-1:0] clip_beats(input logic [FB_COUNT_W-1:0] c);
        if (c > FB_COUNT_W'(MAX_BEATS)) return CW'(MAX_BEATS);
        return CW'(c);
    endfunction

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic                  strobe_ok;
    logic                  cmd_acc;
    logic                  beat_acc;
    logic [CW-1:0]         issued_nx;
    logic [CW-1:0]         received_nx;
    logic                  going_done;
    logic                  load;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [CW-1:0]         load_beats;

    assign strobe_ok = mem_request.ReadStrobe && (mem_request.BlockCount != '0);
    assign cmd_acc   = (state == ISSUE) && app_rdy;
    // Beats outside ISSUE/COLLECT, or past the expected count, are dropped.
    assign beat_acc  = ((state == ISSUE) || (state == COLLECT)) &&
                       app_rd_data_valid && (received < beats);

    assign issued_nx   = issued   + CW'(cmd_acc);
    assign received_nx = received + CW'(beat_acc);

    // A command can be the last one while every beat is already in
    // (only possible when the DDR returns in the same cycle), so DONE is
    // reachable straight from ISSUE.
    assign going_done = ((state == ISSUE) && cmd_acc && (issued_nx == beats) &&
                         (received_nx == beats)) ||
                        ((state == COLLECT) && (received_nx == beats));

    // New request load: a fresh strobe in IDLE, or on leaving DONE. In DONE a
    // same-cycle strobe is newer than anything pending, so it wins.
    always_comb begin
        load       = 1'b0;
        load_addr  = mem_request.ReadAddress;
        load_beats = clip_beats(mem_request.BlockCount);
        if (state == IDLE) begin
            load = strobe_ok;
        end else if (state == DONE) begin
            if (strobe_ok) begin
                load = 1'b1;
            end else if (pend_vld) begin
                load       = 1'b1;
                load_addr  = pend_addr;
                load_beats = pend_beats;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Gather buffer: one lane per beat. slot_nx folds in a beat landing this
    // cycle so the final beat is visible when Data is published.
    // -----------------------------------------------------------------------
    logic [MAX_BEATS-1:0][APP_DATA_WIDTH-1:0] slot_q;
    logic [MAX_BEATS-1:0][APP_DATA_WIDTH-1:0] slot_nx;
    logic [MAX_BEATS-1:0]                     slot_we;

    for (genvar i = 0; i < MAX_BEATS; i++) begin : g_slot
        assign slot_we[i] = beat_acc && (received == CW'(i));
        assign slot_nx[i] = slot_we[i] ? app_rd_data : slot_q[i];

        fb_beat_slot #(.W(APP_DATA_WIDTH)) u_slot (
            .clk    (clk),
            .resetn (resetn),
            .clr    (load),
            .we     (slot_we[i]),
            .d      (app_rd_data),
            .q      (slot_q[i])
        );
    end

    // -----------------------------------------------------------------------
    // Fetch FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            base_addr  <= '0;
            beats      <= '0;
            issued     <= '0;
            received   <= '0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_beats <= '0;
            read_data  <= '0;
        end else begin
            read_data.Valid <= going_done;
            if (going_done) begin
                read_data.ReadAddress <= base_addr;
                read_data.Data        <= slot_nx;
            end

            // Strobes seen mid-transaction park here; newest one wins.
            if (strobe_ok && (state == ISSUE || state == COLLECT)) begin
                pend_vld   <= 1'b1;
                pend_addr  <= mem_request.ReadAddress;
                pend_beats <= clip_beats(mem_request.BlockCount);
            end

            if (load) begin
                base_addr <= load_addr;
                beats     <= load_beats;
                issued    <= '0;
                received  <= '0;
            end else begin
                issued    <= issued_nx;
                received  <= received_nx;
            end

            case (state)
                IDLE: begin
                    if (load) state <= ISSUE;
                end
                ISSUE: begin
                    if (cmd_acc && (issued_nx == beats))
                        state <= going_done ? DONE : COLLECT;
                end
                COLLECT: begin
                    if (going_done) state <= DONE;
                end
                DONE: begin
                    // Whatever was pending has been consumed or superseded.
                    pend_vld <= 1'b0;
                    state    <= load ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state/counters.
    assign app_en   = (state == ISSUE);
    assign app_cmd  = 3'b001;
    assign app_addr = base_addr + ADDR_WIDTH'(issued) * ADDR_WIDTH'(STRIDE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_frame_buffer_fetch.sv
// ---------------------------------------------------------------------------
// Bench for frame_buffer_fetch. A request-level model predicts which requests
// get served (pending/newest-wins rules), the command address sequence and
// the gathered block; a small DDR responder returns beats in order with
// random latency and random app_rdy.
// ---------------------------------------------------------------------------
module tb_frame_buffer_fetch;
    import frame_buffer_fetch_pkg::*;

    localparam int AW     = 28;
    localparam int DW     = 128;
    localparam int MB     = 4;
    localparam int STRIDE = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    MemoryReadRequest mem_request;
    MemoryReadData    read_data;
    logic [AW-1:0]    app_addr;
    logic [2:0]       app_cmd;
    logic             app_en, app_rdy, app_rd_data_valid, busy;
    logic [DW-1:0]    app_rd_data;

    frame_buffer_fetch dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_request       (mem_request),
        .read_data         (read_data),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_en            (app_en),
        .app_rdy           (app_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .busy              (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0]  addr;
        int             n;
        logic [511:0]   data;
        logic [511:0]   mask;
    } req_t;

    typedef struct {
        logic [DW-1:0] d;
        int            rdy_cyc;
    } beat_t;

    req_t          exp_q[$];
    logic [AW-1:0] exp_cmd[$];
    beat_t         ret_q[$];
    bit            pend_v;
    req_t          pend_r;
    int            head_rx, last_beat_cyc;
    bit            hold_v;
    logic [AW-1:0] hold_a;

    int rdy_mode, lat_min, lat_max, beat_pct;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {4'h0, a};
        return {x ^ 32'hA5A5_5A5A, ~x, x * 32'd2654435761, x + 32'h1234_5678};
    endfunction

    function automatic req_t make_req(input logic [AW-1:0] a, input int cnt);
        req_t r;
        logic [AW-1:0] ak;
        r.addr = a;
        r.n    = (cnt > MB) ? MB : cnt;
        r.data = '0;
        r.mask = '0;
        for (int k = 0; k < r.n; k++) begin
            ak = a + AW'(k * STRIDE);      // wraps modulo 2^AW
            r.data[k*DW +: DW] = mem_word(ak);
            r.mask[k*DW +: DW] = '1;
        end
        return r;
    endfunction

    task automatic push_req(input req_t r);
        exp_q.push_back(r);
        for (int k = 0; k < r.n; k++) exp_cmd.push_back(r.addr + AW'(k * STRIDE));
    endtask

    // One clock cycle, everything evaluated at the falling edge.
    task automatic cycle(input bit stb, input logic [AW-1:0] addr, input int cnt, input bit stray);
        req_t r;
        beat_t b;
        bit ok;
        @(negedge clk);
        cyc++;

        // Completed block this cycle?
        if (read_data.Valid) begin
            if (exp_q.size() == 0) chk("valid_unexpected", read_data.Valid, 0);
            else begin
                r = exp_q.pop_front();
                chk("rd_addr", read_data.ReadAddress, r.addr);
                chk("rd_data", read_data.Data & r.mask, r.data);
                chk("valid_latency", cyc, last_beat_cyc + 1);
                head_rx = 0;
            end
        end

        // Request acceptance rules.
        ok = stb && (cnt != 0);
        if (read_data.Valid) begin
            if (ok) begin push_req(make_req(addr, cnt)); pend_v = 0; end
            else if (pend_v) begin push_req(pend_r); pend_v = 0; end
        end else if (ok) begin
            if (busy) begin pend_v = 1; pend_r = make_req(addr, cnt); end
            else push_req(make_req(addr, cnt));
        end
        mem_request.ReadStrobe  = stb;
        mem_request.ReadAddress = addr;
        mem_request.BlockCount  = 8'(cnt);

        // DDR responder.
        case (rdy_mode)
            0:       app_rdy = ($urandom_range(1) == 1);
            1:       app_rdy = 1'b1;
            default: app_rdy = (cyc % 3 == 1);
        endcase
        app_rd_data_valid = 1'b0;
        if (stray) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = {$urandom, $urandom, $urandom, $urandom};
        end else if (ret_q.size() > 0 && ret_q[0].rdy_cyc <= cyc &&
                     $urandom_range(99) < beat_pct) begin
            b = ret_q.pop_front();
            app_rd_data_valid = 1'b1;
            app_rd_data = b.d;
            if (exp_q.size() > 0) begin
                head_rx++;
                if (head_rx == exp_q[0].n) last_beat_cyc = cyc;
            end
        end

        // Command channel.
        if (hold_v && app_en) chk("addr_hold", app_addr, hold_a);
        if (app_en && app_rdy) begin
            chk("app_cmd", app_cmd, 3'b001);
            if (exp_cmd.size() == 0) chk("cmd_unexpected", app_en, 0);
            else chk("cmd_addr", app_addr, exp_cmd.pop_front());
            b.d = mem_word(app_addr);
            b.rdy_cyc = cyc + $urandom_range(lat_max, lat_min);
            ret_q.push_back(b);
        end
        hold_v = app_en && !app_rdy;
        hold_a = app_addr;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < budget) begin
            cycle(0, '0, 0, 0);
            i++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_cmd.delete();
        ret_q.delete();
        pend_v = 0;
        head_rx = 0;
        hold_v = 0;
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_app_en"}, app_en, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_valid"}, read_data.Valid, 0);
        chk({pfx, "_app_addr"}, app_addr, 0);
        chk({pfx, "_rd_addr"}, read_data.ReadAddress, 0);
        chk({pfx, "_data"}, read_data.Data, 0);
    endtask

    logic [511:0] saved;

    initial begin
        mem_request = '0;
        app_rdy = 0;
        app_rd_data_valid = 0;
        app_rd_data = '0;
        clear_model();
        last_beat_cyc = 0;
        rdy_mode = 1; lat_min = 1; lat_max = 1; beat_pct = 100;

        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Single request, immediate accept and one-cycle return.
        cycle(1, 28'h1000, 4, 0);
        cycle(0, '0, 0, 0);
        chk("lat_app_en", app_en, 1);
        chk("lat_app_addr", app_addr, 28'h1000);
        drain(50);

        // Backpressure 1,0,0,1,... with varied return latency.
        rdy_mode = 2; lat_min = 1; lat_max = 4;
        cycle(1, 28'h2340, 4, 0);
        drain(80);

        // Overlap: beat 0 lands with the third command acceptance.
        rdy_mode = 1; lat_min = 2; lat_max = 2;
        cycle(1, 28'h3000, 4, 0);
        drain(50);

        // Pending: A, then B and C while busy -> A then C.
        rdy_mode = 0; lat_min = 1; lat_max = 3;
        cycle(1, 28'h4000, 4, 0);
        cycle(1, 28'h4100, 3, 0);
        cycle(1, 28'h4200, 2, 0);
        drain(100);

        // Zero count is ignored.
        cycle(1, 28'h5000, 0, 0);
        repeat (4) cycle(0, '0, 0, 0);
        chk("cnt0_busy", busy, 0);
        chk("cnt0_app_en", app_en, 0);

        // Count above MAX_BEATS clamps to 4.
        rdy_mode = 1; lat_min = 1; lat_max = 2;
        cycle(1, 28'h6000, 7, 0);
        drain(50);

        // Address wrap.
        cycle(1, 28'hFFFFFF8, 2, 0);
        drain(50);

        // Stray beats while idle leave Data alone.
        saved = read_data.Data;
        repeat (4) cycle(0, '0, 0, 1);
        chk("stray_idle_data", read_data.Data, saved);

        // Randomized traffic.
        rdy_mode = 0; lat_min = 1; lat_max = 6; beat_pct = 70;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0)
                cycle(1, AW'($urandom), $urandom_range(9), 0);
            else
                cycle(0, '0, 0, 0);
        end
        drain(300);

        // Reset mid-COLLECT, then stale beats arriving afterwards.
        rdy_mode = 1; lat_min = 50; lat_max = 50; beat_pct = 100;
        cycle(1, 28'h7000, 4, 0);
        repeat (6) cycle(0, '0, 0, 0);
        chk("midrst_busy_before", busy, 1);
        #2 resetn = 1'b0;
        #1;
        check_reset_values("midrst");
        clear_model();
        mem_request = '0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) cycle(0, '0, 0, 1);
        chk("post_rst_stray_data", read_data.Data, 0);
        chk("post_rst_busy", busy, 0);
        repeat (2) cycle(0, '0, 0, 0);
        chk("final_outstanding", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
